// File: rtl/rect_copy_controller.sv
`timescale 1ns/1ps
// Frame-boundary copy engine: streams the rect table from data memory into the GPU rect buffer,
// then writes the latched button word back to data memory. Optional macro: RECT_COPY_CHECKSUM_EN.
module rect_copy_controller #(
    parameter int unsigned             ADDR_WIDTH     = 13,
    parameter int unsigned             DATA_WIDTH     = 16,
    parameter int unsigned             RECT_COUNT     = 64,
    parameter int unsigned             RECT_WORDS     = 5,
    parameter logic [ADDR_WIDTH-1:0]   RECT_BASE      = 13'h1000,
    parameter logic [ADDR_WIDTH-1:0]   BTN_ADDR       = 13'h0FFF,
    parameter int unsigned             GPU_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      copy_start,
    input  logic                      copy,
    input  logic [DATA_WIDTH-1:0]     buttons,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      gpu_we,
    output logic [GPU_ADDR_WIDTH-1:0] gpu_addr,
    output logic [DATA_WIDTH-1:0]     gpu_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
`ifdef RECT_COPY_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]     checksum
`endif
);

    localparam int unsigned N     = RECT_COUNT * RECT_WORDS;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        FLUSH = 3'd2,
        BTN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     btn_q, btn_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic                      mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic                      gpu_we_q, gpu_we_d;
    logic [GPU_ADDR_WIDTH-1:0] gpu_addr_q, gpu_addr_d;
    logic [DATA_WIDTH-1:0]     gpu_wdata_q, gpu_wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overrun_q, overrun_d;
`ifdef RECT_COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]     csum_q, csum_d;
`endif

    // Next-state and registered-output logic; each state's outputs appear the cycle after it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        btn_d       = btn_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        gpu_we_d    = 1'b0;
        gpu_addr_d  = gpu_addr_q;
        gpu_wdata_d = gpu_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
`ifdef RECT_COPY_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (copy_start && copy) begin
                    btn_d      = buttons;
                    cnt_d      = '0;
                    mem_addr_d = RECT_BASE;
                    busy_d     = 1'b1;
                    state_d    = READ;
`ifdef RECT_COPY_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            READ: begin
                // Read data for word cnt-1 is on mem_rdata now
                if (cnt_q != '0) begin
                    gpu_we_d    = 1'b1;
                    gpu_addr_d  = GPU_ADDR_WIDTH'(cnt_q - CNT_W'(1));
                    gpu_wdata_d = mem_rdata;
                end
                cnt_d      = cnt_q + CNT_W'(1);
                mem_addr_d = RECT_BASE + ADDR_WIDTH'(cnt_d);
                if (cnt_q == LAST_CNT) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                gpu_we_d    = 1'b1;
                gpu_addr_d  = GPU_ADDR_WIDTH'(N - 1);
                gpu_wdata_d = mem_rdata;
                state_d     = BTN;
            end
            BTN: begin
                mem_addr_d  = BTN_ADDR;
                mem_we_d    = 1'b1;
                mem_wdata_d = btn_q;
                state_d     = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Losing the copy window mid-transfer abandons the frame
        if ((state_q inside {READ, FLUSH, BTN}) && !copy) begin
            state_d   = IDLE;
            gpu_we_d  = 1'b0;
            mem_we_d  = 1'b0;
            busy_d    = 1'b0;
            overrun_d = 1'b1;
        end

`ifdef RECT_COPY_CHECKSUM_EN
        if (gpu_we_d) begin
            csum_d = csum_q ^ gpu_wdata_d;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            gpu_we_q    <= 1'b0;
            gpu_addr_q  <= '0;
            gpu_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RECT_COPY_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_q       <= btn_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            gpu_we_q    <= gpu_we_d;
            gpu_addr_q  <= gpu_addr_d;
            gpu_wdata_q <= gpu_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
`ifdef RECT_COPY_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign gpu_we    = gpu_we_q;
    assign gpu_addr  = gpu_addr_q;
    assign gpu_wdata = gpu_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
`ifdef RECT_COPY_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_rect_copy_controller.sv
`timescale 1ns/1ps
// Directed bench for rect_copy_controller: full copies, ignored restart, abort, async reset,
// and the checksum option when RECT_COPY_CHECKSUM_EN is defined.
module tb_rect_copy_controller;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;
    localparam int unsigned GW = 9;
    localparam int unsigned N  = 320;
    localparam logic [AW-1:0] RB = 13'h1000;
    localparam logic [AW-1:0] BA = 13'h0FFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          copy_start;
    logic          copy;
    logic [DW-1:0] buttons;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          gpu_we;
    logic [GW-1:0] gpu_addr;
    logic [DW-1:0] gpu_wdata;
    logic          busy;
    logic          done;
    logic          overrun;
`ifdef RECT_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    rect_copy_controller dut (
        .clk        (clk),
        .reset      (reset),
        .copy_start (copy_start),
        .copy       (copy),
        .buttons    (buttons),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .gpu_we     (gpu_we),
        .gpu_addr   (gpu_addr),
        .gpu_wdata  (gpu_wdata),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
`ifdef RECT_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Rect table store with 1-cycle read latency; button writes are observed, not stored
    logic [DW-1:0] mem [0:8191];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int            n_vec;
    int            n_err;
    int            gpu_n;
    int            first_gpu_k;
    int            last_gpu_addr;
    int            done_k;
    int            done_n;
    int            memw_n;
    int            overlap_n;
    logic [AW-1:0] memw_addr;
    logic [DW-1:0] memw_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string t);
        chk({t, "_mem_port"}, 32'({mem_we, mem_addr, mem_wdata}), 32'(0));
        chk({t, "_gpu_port"}, 32'({gpu_we, gpu_addr, gpu_wdata}), 32'(0));
        chk({t, "_flags"},    32'({busy, done, overrun}), 32'(0));
`ifdef RECT_COPY_CHECKSUM_EN
        chk({t, "_checksum"}, 32'(checksum), 32'(0));
`endif
    endtask

    // k counts clock edges after the one that samples copy_start; sampled on negedges
    task automatic run_copy(input int abort_at, input int restart_at,
                            input logic [DW-1:0] btn, input logic [DW-1:0] btn2);
        gpu_n = 0; first_gpu_k = -1; last_gpu_addr = -1; done_k = -1; done_n = 0;
        memw_n = 0; overlap_n = 0; memw_addr = '0; memw_data = '0;
        @(negedge clk); copy_start = 1'b1; buttons = btn;
        @(negedge clk); copy_start = 1'b0;
        for (int k = 0; k < int'(N) + 8; k++) begin
            if (k > 0) @(negedge clk);
            if (gpu_we) begin
                if (first_gpu_k < 0) first_gpu_k = k;
                chk("gpu_addr", 32'(gpu_addr), 32'(gpu_n));
                chk("gpu_data", 32'(gpu_wdata), 32'(mem[RB + AW'(gpu_n)]));
                last_gpu_addr = int'(gpu_addr);
                gpu_n++;
            end
            if (mem_we) begin
                memw_n++; memw_addr = mem_addr; memw_data = mem_wdata;
            end
            if (gpu_we && mem_we) overlap_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == abort_at) copy = 1'b0;
            copy_start = (k == restart_at);
            if (k == restart_at) buttons = btn2;
        end
    endtask

    task automatic check_full(input string t, input logic [DW-1:0] btn, input logic ovr);
        chk({t, "_gpu_count"},   32'(gpu_n),         32'(N));
        chk({t, "_first_gpu_k"}, 32'(first_gpu_k),   32'(2));
        chk({t, "_last_addr"},   32'(last_gpu_addr), 32'(N - 1));
        chk({t, "_done_cycle"},  32'(done_k),        32'(N + 3));
        chk({t, "_done_count"},  32'(done_n),        32'(1));
        chk({t, "_btn_writes"},  32'(memw_n),        32'(1));
        chk({t, "_btn_addr"},    32'(memw_addr),     32'(BA));
        chk({t, "_btn_data"},    32'(memw_data),     32'(btn));
        chk({t, "_we_overlap"},  32'(overlap_n),     32'(0));
        chk({t, "_busy_after"},  32'(busy),          32'(0));
        chk({t, "_overrun"},     32'(overrun),       32'(ovr));
    endtask

    initial begin
        logic seen;
        n_vec = 0; n_err = 0;
        reset = 1'b1; copy = 1'b1; copy_start = 1'b0; buttons = '0;
        for (int i = 0; i < 8192; i++) mem[AW'(i)] = '0;
        for (int i = 0; i < int'(N); i++) mem[RB + AW'(i)] = DW'(i) ^ 16'hA5A5;

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;

        // Start request while the copy window is already closed
        @(negedge clk); copy = 1'b0; copy_start = 1'b1;
        @(negedge clk); copy_start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | busy | gpu_we | mem_we | done | overrun;
        end
        chk("nostart_activity", 32'(seen), 32'(0));
        copy = 1'b1;

        run_copy(-1, -1, 16'h0013, 16'h0013);
        check_full("basic", 16'h0013, 1'b0);

        run_copy(-1, 50, 16'h0022, 16'h7777);
        check_full("restart", 16'h0022, 1'b0);

        run_copy(100, -1, 16'h0055, 16'h0055);
        chk("abort_gpu_le101", 32'(gpu_n <= 101), 32'(1));
        chk("abort_btn_writes", 32'(memw_n), 32'(0));
        chk("abort_done",       32'(done_n), 32'(0));
        chk("abort_overrun",    32'(overrun), 32'(1));
        chk("abort_busy",       32'(busy), 32'(0));
        chk("abort_overlap",    32'(overlap_n), 32'(0));
        copy = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_overrun_sticky", 32'(overrun), 32'(1));

        run_copy(-1, -1, 16'h0044, 16'h0044);
        check_full("after_abort", 16'h0044, 1'b1);

        // Asynchronous reset landing between edges in the middle of READ
        @(negedge clk); copy_start = 1'b1; buttons = 16'h0066;
        @(negedge clk); copy_start = 1'b0;
        repeat (50) @(negedge clk);
        chk("midread_busy", 32'(busy), 32'(1));
        #1 reset = 1'b1;
        #1 chk_zero_outputs("async_reset");
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | busy | gpu_we | mem_we | done;
        end
        chk("post_reset_idle", 32'(seen), 32'(0));

        run_copy(-1, -1, 16'h0099, 16'h0099);
        check_full("post_reset", 16'h0099, 1'b0);

`ifdef RECT_COPY_CHECKSUM_EN
        for (int i = 0; i < int'(N); i++) mem[RB + AW'(i)] = 16'h0001;
        run_copy(-1, -1, 16'h0001, 16'h0001);
        chk("csum_even_ones", 32'(checksum), 32'(16'h0000));
        mem[RB] = 16'h8001;
        run_copy(-1, -1, 16'h0001, 16'h0001);
        chk("csum_word0_8001", 32'(checksum), 32'(16'h8000));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rect_copy_controller.md
Name: rect_copy_controller

Overview:
- Frame-boundary copy engine. On a copy_start pulse it streams the rect table out of data memory into the GPU rect buffer. It then writes the latched button state word back into data memory and pulses done.
- Owns the data-memory port only while the copy flag is high. The memory muxes are driven externally by copy.
- Sits between the frame-sync controller (copy_start/copy), data memory (1-cycle read latency) and the GPU rect buffer.

Parameters:
- ADDR_WIDTH, 13, data memory word-address width.
- DATA_WIDTH, 16, memory and rect word width.
- RECT_COUNT, 64, number of rects per frame.
- RECT_WORDS, 5, words per rect (x, y, w, h, color).
- RECT_BASE, 13'h1000, data-memory address of rect 0 word 0.
- BTN_ADDR, 13'h0FFF, data-memory address receiving the button word.
- GPU_ADDR_WIDTH, 9, GPU rect buffer address width. Must satisfy 2^GPU_ADDR_WIDTH >= RECT_COUNT*RECT_WORDS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- copy_start  in  1  1-cycle pulse: begin copy
- copy  in  1  copy window flag (high for the whole vsync period)
- buttons  in  DATA_WIDTH  raw button state, sampled at copy_start
- mem_addr  out  ADDR_WIDTH  data-memory address
- mem_we  out  1  data-memory write enable
- mem_wdata  out  DATA_WIDTH  data-memory write data
- mem_rdata  in  DATA_WIDTH  data-memory read data, valid 1 cycle after mem_addr
- gpu_we  out  1  GPU rect buffer write enable
- gpu_addr  out  GPU_ADDR_WIDTH  GPU rect buffer address
- gpu_wdata  out  DATA_WIDTH  GPU rect buffer write data
- busy  out  1  engine active
- done  out  1  1-cycle pulse on completion
- overrun  out  1  sticky: copy fell before completion

Behaviour:
- Reset (async) state: FSM=IDLE. mem_addr=0, mem_we=0, mem_wdata=0, gpu_we=0, gpu_addr=0, gpu_wdata=0, busy=0, done=0, overrun=0, word counter=0.
- Let N = RECT_COUNT*RECT_WORDS (320 by default).
- IDLE:
  - On copy_start=1: latch buttons into btn_reg, counter<=0, go to READ, busy<=1.
  - copy_start while not IDLE is ignored.
- READ:
  - Each cycle: mem_addr = RECT_BASE + counter, mem_we=0.
  - The write to the GPU is delayed one cycle: gpu_we=1, gpu_addr=counter-1, gpu_wdata=mem_rdata. This holds for every cycle after the first READ cycle.
  - After issuing counter=N-1, go to FLUSH.
- FLUSH: one cycle. gpu_we=1, gpu_addr=N-1, gpu_wdata=mem_rdata. Go to BTN.
- BTN: one cycle. mem_addr=BTN_ADDR, mem_we=1, mem_wdata=btn_reg, gpu_we=0. Go to DONE.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Total latency from copy_start to the done pulse is N+3 cycles. gpu_we is high for exactly N cycles.
- Address arithmetic: RECT_BASE+counter is truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). counter is wide enough to hold N.
- Abort: if copy=0 in READ, FLUSH or BTN:
  - Set overrun=1 (sticky until reset) and go to IDLE immediately.
  - No further gpu_we or mem_we. busy=0 next cycle. No done pulse.
- copy_start and copy falling in the same IDLE cycle: no start, no overrun.
- gpu_we and mem_we are never high in the same cycle.
- All outputs are registered (no combinational input-to-output paths).

Optional Feature:
- Macro RECT_COPY_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (DATA_WIDTH).
  - Running XOR of every gpu_wdata written. Cleared on copy_start, held after done.
  - Reset value 0. Not updated on aborted copies beyond the words already written.
- When undefined: the port and logic are absent.

Test Plan:
- Basic copy:
  - Stimulus: mem[RECT_BASE+i] = i ^ 16'hA5A5 for i in 0..319. copy held high, 1-cycle copy_start, buttons=16'h0013.
  - Response: 320 GPU writes with gpu_addr=i and data i^16'hA5A5. Then mem[13'h0FFF] is written with 16'h0013. done pulses at cycle 323. overrun=0.
- Pipeline alignment: mem_rdata delayed exactly 1 cycle -> no gpu_we in the first READ cycle. The last write lands at gpu_addr=319.
- Abort:
  - Stimulus: drop copy at word 100.
  - Response: gpu_we count <= 101, no button write, no done, overrun=1 until reset. A subsequent full copy still succeeds with overrun still 1.
- Ignored start: second copy_start pulse at word 50 -> sequence unchanged, done once, button word is the value sampled at the first start.
- Async reset mid-READ: reset asserted between clock edges -> all outputs 0 immediately. After release, engine in IDLE until the next copy_start.
- Checksum (RECT_COPY_CHECKSUM_EN): all words 16'h0001 with N=320 (even count) -> checksum=16'h0000. Word 0 set to 16'h8001 -> checksum=16'h8000.
